pixel_stream_mux: RTL and testbench

Frame-aware, parametrised N-input pixel stream multiplexer with valid/ready handshaking. It is the successor to the plain two-input pixel select. It sits between multiple pixel sources (camera, test pattern, processed streams) and a single downstream consumer. Source changes take effect only on frame boundaries, so the output never carries a torn frame. Output is registered through a 2-entry skid buffer for full throughput.

---
 rtl/pixel_stream_pkg.sv | 10 +
 rtl/pixel_skid_buffer.sv | 62 ++++++
 rtl/pixel_stream_mux.sv | 119 +++++++++++
 tb/tb_pixel_stream_mux.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_stream_pkg.sv
// Shared constants for the pixel stream blocks: default pixel width and
// the frame-sync FSM encodings.
package pixel_stream_pkg;

  localparam int PIXEL_WIDTH = 24;

  localparam logic [0:0] ST_SYNC = 1'b0;
  localparam logic [0:0] ST_PASS = 1'b1;

endpackage

// File: rtl/pixel_skid_buffer.sv
// Two-entry in-order buffer with ready/valid on both sides. The upstream
// ready is a register, so it never depends combinationally on out_ready.
module pixel_skid_buffer #(
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] mem_reg [2];
  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [1:0]       count_reg;
  logic [1:0]       count_next;
  logic             ready_reg;
  logic             push;
  logic             pop;

  assign push      = in_valid & ready_reg;
  assign out_valid = (count_reg != 2'd0);
  assign pop       = out_valid & out_ready;
  assign out_data  = mem_reg[rd_ptr_reg];
  assign in_ready  = ready_reg;

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + 2'd1;
    end else if (!push && pop) begin
      count_next = count_reg - 2'd1;
    end
  end

  // ready_reg stays low through reset and rises on the first edge after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_reg[0] <= '0;
      mem_reg[1] <= '0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
      ready_reg  <= 1'b0;
    end else begin
      if (push) begin
        mem_reg[wr_ptr_reg] <= in_data;
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_next;
      ready_reg <= (count_next != 2'd2);
    end
  end

endmodule

// File: rtl/pixel_stream_mux.sv
// N-input pixel stream multiplexer that changes source only on frame
// boundaries, re-synchronising to the next SOF of the new source.
module pixel_stream_mux
  import pixel_stream_pkg::*;
#(
  parameter int  DATA_WIDTH = PIXEL_WIDTH,
  parameter int  NUM_INPUTS = 4,
  localparam int SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]            in_valid,
  input  logic [NUM_INPUTS-1:0]            in_sof,
  input  logic [NUM_INPUTS-1:0]            in_eof,
  output logic [NUM_INPUTS-1:0]            in_ready,
  input  logic [SEL_WIDTH-1:0]             select,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_valid,
  output logic                             out_sof,
  output logic                             out_eof,
  input  logic                             out_ready,
  output logic [SEL_WIDTH-1:0]             active_sel,
  output logic                             switching
);

  logic [0:0]            state_reg;
  logic [0:0]            state_next;
  logic [SEL_WIDTH-1:0]  active_sel_reg;
  logic [SEL_WIDTH-1:0]  active_sel_next;
  logic [SEL_WIDTH-1:0]  pending_sel_reg;
  logic                  in_frame_reg;
  logic                  in_frame_next;
  logic                  sel_ok;
  logic                  buf_ready;
  logic                  cur_valid;
  logic                  cur_sof;
  logic                  cur_eof;
  logic [DATA_WIDTH-1:0] cur_data;
  logic                  accept;
  logic                  forward;
  logic [DATA_WIDTH-1:0] ch_data [NUM_INPUTS];

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_chan
    assign ch_data[gi]  = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
    assign in_ready[gi] = buf_ready & (active_sel_reg == SEL_WIDTH'(gi));
  end

  // Out-of-range select codes leave the pending selection untouched.
  always_comb begin
    sel_ok = 1'b0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (select == SEL_WIDTH'(k)) begin
        sel_ok = 1'b1;
      end
    end
  end

  assign cur_valid = in_valid[active_sel_reg];
  assign cur_sof   = in_sof[active_sel_reg];
  assign cur_eof   = in_eof[active_sel_reg];
  assign cur_data  = ch_data[active_sel_reg];
  assign accept    = cur_valid & buf_ready;
  assign forward   = accept & ((state_reg == ST_PASS) | cur_sof);

  always_comb begin
    state_next      = state_reg;
    active_sel_next = active_sel_reg;
    in_frame_next   = in_frame_reg;
    if (forward && cur_eof) begin
      in_frame_next = 1'b0;
    end else if (forward && cur_sof) begin
      in_frame_next = 1'b1;
    end
    if (state_reg == ST_SYNC) begin
      if (forward) begin
        state_next = ST_PASS;
      end
    end else if ((pending_sel_reg != active_sel_reg) &&
                 (!in_frame_reg || (accept && cur_eof))) begin
      state_next      = ST_SYNC;
      active_sel_next = pending_sel_reg;
      in_frame_next   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_SYNC;
      active_sel_reg  <= '0;
      pending_sel_reg <= '0;
      in_frame_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      active_sel_reg <= active_sel_next;
      in_frame_reg   <= in_frame_next;
      if (sel_ok) begin
        pending_sel_reg <= select;
      end
    end
  end

  pixel_skid_buffer #(
    .WIDTH(DATA_WIDTH + 2)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  ({cur_sof, cur_eof, cur_data}),
    .in_valid (forward),
    .in_ready (buf_ready),
    .out_data ({out_sof, out_eof, out_data}),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  assign active_sel = active_sel_reg;
  assign switching  = (state_reg == ST_SYNC);

endmodule

// File: tb/tb_pixel_stream_mux.sv
// Bench for pixel_stream_mux: directed vector table, hand-written corner
// sequences, then random traffic against a frame-level reference model.
module tb_pixel_stream_mux;
  import pixel_stream_pkg::*;

  localparam int DW = PIXEL_WIDTH;
  localparam int N  = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_valid, in_sof, in_eof, in_ready;
  logic [SW-1:0]   select, active_sel;
  logic [DW-1:0]   out_data;
  logic            out_valid, out_sof, out_eof, out_ready, switching;

  logic [3*DW-1:0] in_data3;
  logic [2:0]      in_valid3, in_sof3, in_eof3, in_ready3;
  logic [1:0]      select3, active_sel3;
  logic [DW-1:0]   out_data3;
  logic            out_valid3, out_sof3, out_eof3, out_ready3, switching3;

  pixel_stream_mux #(.DATA_WIDTH(DW), .NUM_INPUTS(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_sof(in_sof), .in_eof(in_eof), .in_ready(in_ready), .select(select),
    .out_data(out_data), .out_valid(out_valid), .out_sof(out_sof),
    .out_eof(out_eof), .out_ready(out_ready), .active_sel(active_sel),
    .switching(switching)
  );

  // Three-input instance: code 3 is out of range there.
  pixel_stream_mux #(.DATA_WIDTH(DW), .NUM_INPUTS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
    .in_sof(in_sof3), .in_eof(in_eof3), .in_ready(in_ready3), .select(select3),
    .out_data(out_data3), .out_valid(out_valid3), .out_sof(out_sof3),
    .out_eof(out_eof3), .out_ready(out_ready3), .active_sel(active_sel3),
    .switching(switching3)
  );

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] pix(input int i, input int k);
    return DW'(32'h0001_0000 + i * 256 + k);
  endfunction

  task automatic idle_inputs();
    in_valid = '0;
    in_sof   = '0;
    in_eof   = '0;
  endtask

  task automatic drive(input int ch, input logic sof, input logic eof, input logic [DW-1:0] d);
    idle_inputs();
    in_valid[ch] = 1'b1;
    in_sof[ch]   = sof;
    in_eof[ch]   = eof;
    in_data[ch*DW +: DW] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [N-1:0]  v, s, e;
    logic [SW-1:0] sel;
    logic          ov, os, oe;
    logic [DW-1:0] od;
    logic [N-1:0]  rdy;
    logic [SW-1:0] act;
    logic          sw;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic [N-1:0] v, input logic [N-1:0] s, input logic [N-1:0] e,
                     input logic [SW-1:0] sel, input logic ov, input logic os, input logic oe,
                     input logic [DW-1:0] od, input logic [N-1:0] rdy, input logic [SW-1:0] act,
                     input logic sw);
    vecs.push_back('{v, s, e, sel, ov, os, oe, od, rdy, act, sw});
  endtask

  // Reference model state: owner channel, pending request, hunting for SOF,
  // inside a frame, and the beats the output is expected to deliver in order.
  int              m_owner, m_pending;
  bit              m_hunting, m_framed, m_armed;
  logic [DW+1:0]   exp_q[$];

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks so far %0d/%0d", passed, total);
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] bexp [3];
    int            got;
    logic          take;
    logic          exp_rdy, acc, fwd, sw_now;
    logic [DW+1:0] beat;

    in_data = '0; idle_inputs(); select = '0; out_ready = 1'b1;
    in_data3 = '0; in_valid3 = '0; in_sof3 = '0; in_eof3 = '0; select3 = '0; out_ready3 = 1'b1;

    // Reset state and ready release timing
    #10;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_active", active_sel, 0);
    chk("rst_switching", switching, 1);
    #12 rst_n = 1'b1;
    #1 chk("ready_before_edge", in_ready, 0);
    tick();
    chk("ready_first_edge", in_ready, 4'b0001);

    // Directed table: SOF hunt, frame forwarding, mid-frame switch to ch2
    add(1, 0, 0, 0,  0, 0, 0, 0,           1, 0, 1);
    add(1, 0, 0, 0,  0, 0, 0, 0,           1, 0, 1);
    add(1, 1, 0, 0,  0, 0, 0, 0,           1, 0, 1);
    add(1, 0, 0, 0,  1, 1, 0, pix(2, 0),   1, 0, 0);
    add(1, 0, 0, 0,  1, 0, 0, pix(3, 0),   1, 0, 0);
    add(1, 0, 1, 0,  1, 0, 0, pix(4, 0),   1, 0, 0);
    add(0, 0, 0, 0,  1, 0, 1, pix(5, 0),   1, 0, 0);
    add(0, 0, 0, 0,  0, 0, 0, 0,           1, 0, 0);
    add(1, 1, 0, 0,  0, 0, 0, 0,           1, 0, 0);
    add(1, 0, 0, 2,  1, 1, 0, pix(8, 0),   1, 0, 0);
    add(5, 0, 0, 2,  1, 0, 0, pix(9, 0),   1, 0, 0);
    add(5, 0, 1, 2,  1, 0, 0, pix(10, 0),  1, 0, 0);
    add(5, 0, 0, 2,  1, 0, 1, pix(11, 0),  4, 2, 1);
    add(4, 4, 0, 2,  0, 0, 0, 0,           4, 2, 1);
    add(4, 0, 4, 2,  1, 1, 0, pix(13, 2),  4, 2, 0);
    add(0, 0, 0, 2,  1, 0, 1, pix(14, 2),  4, 2, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      for (int k = 0; k < N; k++) in_data[k*DW +: DW] = pix(i, k);
      in_valid = vecs[i].v; in_sof = vecs[i].s; in_eof = vecs[i].e; select = vecs[i].sel;
      @(negedge clk);
      $display("vec %0d: out_valid=%0b data=%h sof=%0b eof=%0b ready=%b active=%0d sw=%0b",
               i, out_valid, out_data, out_sof, out_eof, in_ready, active_sel, switching);
      chk("vec_out_valid", out_valid, vecs[i].ov);
      if (vecs[i].ov) begin
        chk("vec_out_data", out_data, vecs[i].od);
        chk("vec_out_sof", out_sof, vecs[i].os);
        chk("vec_out_eof", out_eof, vecs[i].oe);
      end
      chk("vec_in_ready", in_ready, vecs[i].rdy);
      chk("vec_active", active_sel, vecs[i].act);
      chk("vec_switching", switching, vecs[i].sw);
      tick();
    end

    // Single-beat frame on ch1 in SYNC with a switch to ch3 pending
    idle_inputs(); select = 2'd1;
    tick(); tick();
    @(negedge clk);
    chk("sb_active1", active_sel, 1);
    chk("sb_sync", switching, 1);
    chk("sb_ready", in_ready, 4'b0010);
    $display("single-beat: active=%0d ready=%b", active_sel, in_ready);
    tick();
    drive(1, 1'b1, 1'b1, pix(20, 1)); select = 2'd3;
    tick();
    idle_inputs();
    @(negedge clk);
    chk("sb_out_valid", out_valid, 1);
    chk("sb_out_beat", {out_sof, out_eof, out_data}, {2'b11, pix(20, 1)});
    chk("sb_pass", switching, 0);
    chk("sb_still1", active_sel, 1);
    tick();
    @(negedge clk);
    chk("sb_active3", active_sel, 3);
    chk("sb_resync", switching, 1);
    chk("sb_drained", out_valid, 0);
    tick();

    // Backpressure on ch3: two beats held, ready low, then in-order drain
    out_ready = 1'b0;
    drive(3, 1'b1, 1'b0, pix(30, 3)); tick();
    drive(3, 1'b0, 1'b0, pix(31, 3)); tick();
    drive(3, 1'b0, 1'b0, pix(32, 3));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data_stable", out_data, pix(30, 3));
      tick();
    end
    out_ready = 1'b1;
    bexp[0] = pix(30, 3); bexp[1] = pix(31, 3); bexp[2] = pix(32, 3);
    got = 0;
    for (int c = 0; c < 10 && got < 3; c++) begin
      @(negedge clk);
      if (out_valid) begin
        $display("drain beat %0d: data=%h", got, out_data);
        chk("bp_drain_data", out_data, bexp[got]);
        got++;
      end
      take = in_valid[3] & in_ready[3];
      tick();
      if (take) idle_inputs();
    end
    chk("bp_drain_count", got, 3);

    // Asynchronous reset mid-frame with two beats buffered
    out_ready = 1'b0;
    drive(3, 1'b0, 1'b0, pix(33, 3)); tick();
    drive(3, 1'b0, 1'b0, pix(34, 3)); tick();
    idle_inputs();
    @(negedge clk);
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_ready", in_ready, 0);
    #2 rst_n = 1'b0; select = 2'd0;
    #1;
    $display("async reset: out_valid=%0b active=%0d", out_valid, active_sel);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_active", active_sel, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_switching", switching, 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_ready_low", in_ready, 0);
    tick();
    chk("rel_ready_high", in_ready, 4'b0001);
    out_ready = 1'b1;
    drive(0, 1'b0, 1'b0, pix(40, 0));
    tick();
    drive(0, 1'b1, 1'b0, pix(41, 0));
    @(negedge clk);
    chk("rel_nonsof_dropped", out_valid, 0);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("rel_sof_valid", out_valid, 1);
    chk("rel_sof_beat", {out_sof, out_data}, {1'b1, pix(41, 0)});
    tick();

    // Out-of-range select on the three-input instance is ignored
    for (int j = 0; j < 8; j++) begin
      in_valid3 = (j < 6) ? 3'b001 : 3'b000;
      in_sof3   = {2'b00, (j == 0 || j == 3)};
      in_eof3   = {2'b00, (j == 2 || j == 5)};
      in_data3[DW-1:0] = pix(100 + j, 0);
      select3   = (j >= 1) ? 2'd3 : 2'd0;
      @(negedge clk);
      if (j >= 1) begin
        $display("oor step %0d: out_valid=%0b data=%h active=%0d", j, out_valid3, out_data3, active_sel3);
        chk("oor_active", active_sel3, 0);
        chk("oor_switching", switching3, 0);
        chk("oor_out_valid", out_valid3, (j <= 6));
        if (j <= 6) chk("oor_out_data", out_data3, pix(99 + j, 0));
      end
      tick();
    end
    in_valid3 = '0;

    // Random traffic against the reference model
    idle_inputs(); select = '0;
    @(negedge clk);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    m_owner = 0; m_pending = 0; m_hunting = 1; m_framed = 0; m_armed = 1;
    exp_q.delete();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int k = 0; k < N; k++) begin
        in_valid[k] = ($urandom_range(0, 3) != 0);
        in_sof[k]   = ($urandom_range(0, 4) == 0);
        in_eof[k]   = ($urandom_range(0, 4) == 0);
        in_data[k*DW +: DW] = DW'($urandom);
      end
      if ($urandom_range(0, 15) == 0) select = SW'($urandom_range(0, N - 1));
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      exp_rdy = m_armed && (exp_q.size() < 2);
      chk("rnd_in_ready", in_ready, exp_rdy ? (64'd1 << m_owner) : 64'd0);
      chk("rnd_active", active_sel, m_owner);
      chk("rnd_switching", switching, m_hunting);
      chk("rnd_out_valid", out_valid, exp_q.size() != 0);
      if (out_valid && exp_q.size() != 0)
        chk("rnd_out_beat", {out_sof, out_eof, out_data}, exp_q[0]);
      if (out_valid && out_ready)
        $display("rnd cyc %0d: beat data=%h sof=%0b eof=%0b from ch%0d", cyc, out_data, out_sof, out_eof, m_owner);

      acc    = exp_rdy && in_valid[m_owner];
      beat   = {in_sof[m_owner], in_eof[m_owner], in_data[m_owner*DW +: DW]};
      fwd    = acc && (!m_hunting || in_sof[m_owner]);
      sw_now = !m_hunting && (m_pending != m_owner) && (!m_framed || (acc && in_eof[m_owner]));
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (fwd) exp_q.push_back(beat);
      if (fwd && in_eof[m_owner]) m_framed = 0;
      else if (fwd && in_sof[m_owner]) m_framed = 1;
      if (fwd) m_hunting = 0;
      if (sw_now) begin
        m_owner = m_pending; m_framed = 0; m_hunting = 1;
      end
      m_pending = int'(select);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
